uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It detects completed frames on the receiver's `rx_done_tick` (rising edge) and captures the 8-bit `dout` into a first-word-fall-through FIFO. Consumers then read bytes on the system clock. A sticky flag records bytes dropped while the FIFO is full.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk` input 1: system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rx_dout` input 8: byte from the receiver; stable whenever `rx_done_tick` is high.
- `rx_done_tick` input 1: receiver done level; a 0→1 transition marks one new byte.
- `rd_en` input 1: pop the head entry; ignored while `empty`.
- `clr_overflow` input 1: clears `overflow`.
- `rd_data` output 8: head entry (FWFT); valid while `empty`=0.
- `empty` output 1: no entries.
- `full` output 1: `count`==DEPTH.
- `count` output AW+1: occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when a byte is dropped.

## Operation
- Edge detect: register `done_q`. Write strobe `wr` = `rx_done_tick` & ~`done_q`. `done_q` resets to 1 because the receiver idles with done=1, so there is no false write after reset.
- Write: on `wr` with !`full`, store `rx_dout` at `wptr` and increment `wptr` modulo DEPTH. Pointers are AW bits and wrap naturally.
- Read: on `rd_en` with !`empty`, increment `rptr`. `rd_data` = `mem[rptr]` (combinational read of the registered array).
- `count` is updated by +1 on a write only, -1 on a read only, and is unchanged on both or neither.
- Full plus simultaneous `wr` and `rd_en`: both are accepted, `count` stays at DEPTH, and `overflow` is not set.
- Empty plus simultaneous `wr` and `rd_en`: the read is ignored and the write is accepted, giving `count`=1.
- Full plus `wr` without `rd_en`: the byte is dropped, memory and pointers are unchanged, and `overflow`←1.
- `clr_overflow` clears `overflow`. If a drop occurs in the same cycle, set wins.
- Reset (async, any time, including mid-write): pointers=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `done_q`=1. Memory contents are not reset. `rd_data` is don't-care while empty.

## Timing
- Write latency: the rising edge of `rx_done_tick` is sampled at clock edge N. The entry is written at edge N, and `empty`/`count` update after edge N, so data is visible one cycle after the sampled edge.
- If `rx_done_tick` is held high, exactly one write occurs. A new byte requires done to fall and rise again.
- Read: `rd_data` advances to the next entry in the cycle after the `rd_en` edge.
- Minimum frame spacing is far above 2 clocks, so back-to-back `wr` on consecutive cycles need not be supported. The FIFO still handles it correctly because each edge is independent.
- No combinational path from `rd_en` to `rd_data`, `empty`, or `full`.

## Configuration
- `UART_RX_FIFO_SYNC_EN`
  - Defined: `rx_done_tick` passes through a 2-flop synchronizer (reset value 1) before edge detection. `rx_dout` is sampled at the write edge; it has been stable for the full stop bit. Write latency becomes 3 clocks from the input edge.
  - Undefined: no synchronizer, and latency is as in Timing. Use only when the receiver is clocked from `clk`.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8.
  - `uart_byte_t` typedef (logic [7:0]).
  - Reset constant for the done level (1'b1).
- One sub-module: `uart_tick_edge`. It provides the optional synchronizer plus rising-edge detector, with output `wr` and parameter `SYNC`.
- Storage is an inferred array (distributed RAM) inside `uart_rx_fifo`.

## Test plan
- Reset release with `rx_done_tick`=1 held: no write; `empty`=1, `count`=0 for 20 cycles.
- Bytes 0x55, 0xA3, 0x0F delivered with done pulsing 1→0→1: after the last, `count`=3; three reads return 0x55, 0xA3, 0x0F, then `empty`=1.
- Write DEPTH=16 bytes 0x00..0x0F, then 0x10: `full`=1, `overflow`=1, and reads return 0x00..0x0F only. `clr_overflow` then clears `overflow`.
- At `full`, issue `wr` and `rd_en` in the same cycle with byte 0x77: `count` stays 16, `overflow`=0, and 0x77 is read last.
- Assert `reset` low asynchronously mid-stream (`count`=5): outputs reset immediately without waiting for `clk`. After release, the next byte 0x3C is read as the first entry.
- With `UART_RX_FIFO_SYNC_EN`: a done edge produces `empty`=0 exactly 3 clocks later; without the macro, 1 clock later.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // The receiver idles with its done level high, so every done-level flop resets to 1.
    localparam logic DONE_RST = 1'b1;

endpackage

// File: rtl/uart_tick_edge.sv
// rtl/uart_tick_edge.sv - optional 2-flop synchronizer plus rising-edge detector for rx_done_tick
module uart_tick_edge
    import uart_pkg::*;
#(
    parameter bit SYNC = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic wr
);

    logic level;
    logic done_q;

    generate
        if (SYNC) begin : g_sync
            logic [1:0] sync_q;

            // Two-flop synchronizer; resets to the idle done level so no edge is seen on release.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= {2{DONE_RST}};
                end else begin
                    sync_q <= {sync_q[0], tick};
                end
            end

            assign level = sync_q[1];
        end else begin : g_direct
            assign level = tick;
        end
    endgenerate

    // Previous done level; a held-high level therefore yields a single strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= DONE_RST;
        end else begin
            done_q <= level;
        end
    end

    assign wr = level & ~done_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive byte FIFO with sticky overflow; UART_RX_FIFO_SYNC_EN adds a done synchronizer
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] rx_dout,
    input  logic                   rx_done_tick,
    input  logic                   rd_en,
    input  logic                   clr_overflow,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overflow
);

`ifdef UART_RX_FIFO_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    uart_byte_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          do_wr;
    logic          do_rd;
    logic          drop;

    uart_tick_edge #(
        .SYNC (SYNC_EN)
    ) u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .tick  (rx_done_tick),
        .wr    (wr)
    );

    // A read frees a slot in the same edge, so a full FIFO still accepts a concurrent write.
    always_comb begin
        do_rd = rd_en & ~empty;
        do_wr = wr & (~full | do_rd);
        drop  = wr & full & ~do_rd;
    end

    // Storage array; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= rx_dout;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign rd_data = mem[rptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Low for one cycle, then rising; held high afterwards. Optionally recorded in the scoreboard.
    task automatic send(input logic [7:0] b, input bit expect_stored);
        @(negedge clk);
        rx_dout      = b;
        rx_done_tick = 1'b0;
        @(negedge clk);
        rx_done_tick = 1'b1;
        if (expect_stored) sb.push_back(b);
        repeat (LAT + 2) @(negedge clk);
    endtask

    // Called at a negedge: check head, pop it, leave at the next negedge.
    task automatic do_read();
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rd_empty", empty, 1'b0);
            chk("rd_data", rd_data, e);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() > 0) do_read();
        chk("drain_empty", empty, 1'b1);
        chk("drain_count", count, 5'd0);
    endtask

    initial begin
        reset        = 1'b0;
        rx_dout      = 8'h00;
        rx_done_tick = 1'b1;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 5'd0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b1;

        // Held-high done across reset release must not write.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_empty", empty, 1'b1);
            chk("idle_count", count, 5'd0);
        end

        // Latency from sampled done edge to visible data.
        @(negedge clk);
        rx_dout      = 8'h55;
        rx_done_tick = 1'b0;
        @(negedge clk);
        rx_done_tick = 1'b1;
        sb.push_back(8'h55);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("latency_empty", empty, (k < LAT) ? 1'b1 : 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("hold_high_count", count, 5'd1);

        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
        chk("three_count", count, 5'd3);
        drain();

        // Fill to DEPTH, then one more byte is dropped.
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 5'd16);
        chk("fill_no_ovf", overflow, 1'b0);
        send(8'h10, 1'b0);
        chk("drop_overflow", overflow, 1'b1);
        chk("drop_count", count, 5'd16);
        drain();
        chk("ovf_sticky", overflow, 1'b1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Full with simultaneous write and read.
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1);
        chk("full2", full, 1'b1);
        @(negedge clk);
        rx_dout      = 8'h77;
        rx_done_tick = 1'b0;
        @(negedge clk);
        rx_done_tick = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        sb.push_back(8'h77);
        do_read();
        chk("simul_full_count", count, 5'd16);
        chk("simul_full_ovf", overflow, 1'b0);
        chk("simul_full_flag", full, 1'b1);
        drain();

        // Empty with simultaneous write and read: read ignored.
        @(negedge clk);
        rx_dout      = 8'hC1;
        rx_done_tick = 1'b0;
        @(negedge clk);
        rx_done_tick = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        chk("simul_empty_pre", empty, 1'b1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        sb.push_back(8'hC1);
        chk("simul_empty_count", count, 5'd1);
        drain();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i), 1'b1);
        chk("pre_reset_count", count, 5'd5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_count", count, 5'd0);
        chk("async_empty", empty, 1'b1);
        chk("async_full", full, 1'b0);
        chk("async_overflow", overflow, 1'b0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_empty", empty, 1'b1);
        send(8'h3C, 1'b1);
        chk("post_reset_count", count, 5'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
